// File: rtl/ttl_input_timestamper_pkg.sv
// ttl_input_timestamper_pkg: shared RTIO event-record layout.
// Holds the 128-bit record width, the field bit positions and a packing helper.
// Both the input timestamper and the output-side controller use these.
package ttl_input_timestamper_pkg;
  localparam int REC_W    = 128;
  localparam int TS_LSB   = 0;
  localparam int TS_W     = 64;
  localparam int RISE_BIT = 64;
  localparam int FALL_BIT = 65;
  localparam int OVF_BIT  = 66;

  typedef logic [REC_W-1:0] rec_t;

  function automatic rec_t pack_record(input logic [TS_W-1:0] ts, input logic rise, input logic fall,
                                       input logic ovf);
    rec_t r;
    r = '0;
    r[TS_LSB +: TS_W] = ts;
    r[RISE_BIT] = rise;
    r[FALL_BIT] = fall;
    r[OVF_BIT] = ovf;
    return r;
  endfunction
endpackage

// File: rtl/ttl_event_fifo.sv
// ttl_event_fifo: first-word-fall-through event FIFO.
// Ports: i_clk, i_rst_n (async active-low), i_flush (sync clear),
//        i_wr/i_din (push), i_rd (pop, ignored when empty),
//        o_dout (head record, zero when empty), o_empty, o_full.
module ttl_event_fifo #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_rd,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_empty,
  output logic             o_full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_do_rd;
  logic             w_do_wr;

  assign o_empty = r_wptr == r_rptr;
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_do_rd = i_rd && !o_empty;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign w_do_wr = i_wr && (!o_full || w_do_rd);
  assign o_dout  = o_empty ? '0 : r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (i_flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_do_wr) r_wptr <= r_wptr + 1'b1;
      if (w_do_rd) r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_wr) r_mem[r_wptr[AW-1:0]] <= i_din;
  end
endmodule

// File: rtl/ttl_input_timestamper.sv
// ttl_input_timestamper: synchronizes a TTL input, timestamps its edges and queues records.
// Ports: s_axi_aclk, s_axi_aresetn (async active-low), input_pulse (async pin),
//        auto_start (capture enable), counter (global time), rise_en/fall_en,
//        flush (sync FIFO/error clear), rd_en (pop), fifo_dout (FWFT head),
//        empty, full, overflow_error (sticky drop flag).
module ttl_input_timestamper
  import ttl_input_timestamper_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic             s_axi_aclk,
  input  logic             s_axi_aresetn,
  input  logic             input_pulse,
  input  logic             auto_start,
  input  logic [63:0]      counter,
  input  logic             rise_en,
  input  logic             fall_en,
  input  logic             flush,
  input  logic             rd_en,
  output logic [REC_W-1:0] fifo_dout,
  output logic             empty,
  output logic             full,
  output logic             overflow_error
);
  // Startup guard: sync chain and previous-level flop must settle before edges count.
  localparam logic [2:0] ARM_DONE = 3'(SYNC_STAGES + 1);

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [TS_W-1:0]        r_cnt_dly [SYNC_STAGES];
  logic                   r_prev;
  logic [2:0]             r_arm;
  logic                   r_ovf;
  logic                   r_pend;
  logic                   w_lvl;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_event;
  logic                   w_accept;
  rec_t                   w_rec;

  // Assert asynchronously, release on the clock.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) r_rst_sync <= '0;
    else                r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // The counter delay line matches the synchronizer depth, so the stamp is the
  // counter value at the edge where the first flop captured the new level.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_arm  <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) r_cnt_dly[i] <= '0;
    end else begin
      r_sync       <= {r_sync[SYNC_STAGES-2:0], input_pulse};
      r_prev       <= r_sync[SYNC_STAGES-1];
      r_arm        <= (r_arm == ARM_DONE) ? r_arm : r_arm + 3'd1;
      r_cnt_dly[0] <= counter;
      for (int i = 1; i < SYNC_STAGES; i++) r_cnt_dly[i] <= r_cnt_dly[i-1];
    end
  end

  assign w_lvl    = r_sync[SYNC_STAGES-1];
  assign w_rise   = w_lvl && !r_prev;
  assign w_fall   = !w_lvl && r_prev;
  assign w_event  = (r_arm == ARM_DONE) && auto_start && !flush &&
                    ((w_rise && rise_en) || (w_fall && fall_en));
  assign w_accept = w_event && (!full || rd_en);
  assign w_rec    = pack_record(r_cnt_dly[SYNC_STAGES-1], w_rise, w_fall, r_pend);

  // r_pend marks the next accepted record as following a dropped one.
  always_ff @(posedge s_axi_aclk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ovf  <= 1'b0;
      r_pend <= 1'b0;
    end else if (flush) begin
      r_ovf  <= 1'b0;
      r_pend <= 1'b0;
    end else if (w_event && !w_accept) begin
      r_ovf  <= 1'b1;
      r_pend <= 1'b1;
    end else if (w_accept) begin
      r_pend <= 1'b0;
    end
  end
  assign overflow_error = r_ovf;

  ttl_event_fifo #(
    .WIDTH(REC_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (s_axi_aclk),
    .i_rst_n(w_rst_n),
    .i_flush(flush),
    .i_wr   (w_accept),
    .i_din  (w_rec),
    .i_rd   (rd_en),
    .o_dout (fifo_dout),
    .o_empty(empty),
    .o_full (full)
  );
endmodule

// File: tb/tb_ttl_input_timestamper.sv
// tb_ttl_input_timestamper: directed self-checking bench for ttl_input_timestamper.
module tb_ttl_input_timestamper;
  logic         s_axi_aclk = 1'b0;
  logic         s_axi_aresetn = 1'b0;
  logic         input_pulse = 1'b0;
  logic         auto_start = 1'b0;
  logic [63:0]  counter = 64'd0;
  logic         rise_en = 1'b0;
  logic         fall_en = 1'b0;
  logic         flush = 1'b0;
  logic         rd_en = 1'b0;
  logic [127:0] fifo_dout;
  logic         empty;
  logic         full;
  logic         overflow_error;

  int n_vec = 0;
  int n_err = 0;
  logic [127:0] q[$];
  logic [127:0] rec;
  logic [127:0] rec_r;
  logic [127:0] rec_f;
  logic [63:0]  ts_a;

  ttl_input_timestamper #(.SYNC_STAGES(2), .FIFO_DEPTH(16)) dut (
    .s_axi_aclk    (s_axi_aclk),
    .s_axi_aresetn (s_axi_aresetn),
    .input_pulse   (input_pulse),
    .auto_start    (auto_start),
    .counter       (counter),
    .rise_en       (rise_en),
    .fall_en       (fall_en),
    .flush         (flush),
    .rd_en         (rd_en),
    .fifo_dout     (fifo_dout),
    .empty         (empty),
    .full          (full),
    .overflow_error(overflow_error)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;
  always @(posedge s_axi_aclk) begin
    #1 counter = counter + 64'd1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge s_axi_aclk);
      #2;
    end
  endtask

  task automatic pop();
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
  endtask

  task automatic toggle(output logic [127:0] r);
    input_pulse = !input_pulse;
    r = {61'b0, 1'b0, !input_pulse, input_pulse, counter};
    step(4);
  endtask

  task automatic drain(input string tag);
    int n;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      check(tag, fifo_dout, q.pop_front());
      pop();
    end
    check({tag, "_empty"}, empty, 1);
  endtask

  initial begin
    int guard;
    step(3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_dout", fifo_dout, 0);
    check("rst_ovf", overflow_error, 0);
    s_axi_aresetn = 1'b1;
    auto_start = 1'b1;
    rise_en = 1'b1;
    step(10);

    // rising edge captured at counter=100
    guard = 0;
    while (counter != 64'd100 && guard < 500) begin
      step(1);
      guard++;
    end
    check("t1_cnt", counter, 100);
    input_pulse = 1'b1;
    step(1);
    check("t1_empty_e0", empty, 1);
    step(1);
    check("t1_empty_e1", empty, 1);
    step(1);
    check("t1_empty_e2", empty, 0);
    check("t1_rec", fifo_dout, {61'b0, 3'b001, 64'd100});
    pop();
    check("t1_popped", empty, 1);

    // rise only, then both edges of a 10-cycle pulse
    input_pulse = 1'b0;
    step(4);
    check("t2_nofall", empty, 1);
    input_pulse = 1'b1;
    ts_a = counter;
    step(10);
    input_pulse = 1'b0;
    step(5);
    check("t2_rise", fifo_dout, {61'b0, 3'b001, ts_a});
    pop();
    check("t2_one", empty, 1);
    fall_en = 1'b1;
    input_pulse = 1'b1;
    ts_a = counter;
    step(10);
    input_pulse = 1'b0;
    step(5);
    check("t2b_rise", fifo_dout, {61'b0, 3'b001, ts_a});
    pop();
    check("t2b_fall", fifo_dout, {61'b0, 3'b010, ts_a + 64'd10});
    pop();
    check("t2b_empty", empty, 1);

    // 17 edges without reads overflow the 16-entry FIFO
    for (int i = 0; i < 17; i++) begin
      toggle(rec);
      if (i < 16) q.push_back(rec);
    end
    check("t3_full", full, 1);
    check("t3_ovf", overflow_error, 1);
    pop();
    void'(q.pop_front());
    check("t3_notfull", full, 0);
    toggle(rec);
    rec[66] = 1'b1;
    q.push_back(rec);
    drain("t3_drain");
    check("t3_ovf_sticky", overflow_error, 1);

    // flush while an event is in flight
    input_pulse = !input_pulse;
    step(2);
    flush = 1'b1;
    step(1);
    flush = 1'b0;
    check("t5_empty", empty, 1);
    check("t5_ovf", overflow_error, 0);
    step(4);
    check("t5_nostale", empty, 1);
    check("t5_dout", fifo_dout, 0);

    // full FIFO with simultaneous pop and write
    for (int i = 0; i < 16; i++) begin
      toggle(rec);
      q.push_back(rec);
    end
    check("t4_full", full, 1);
    input_pulse = !input_pulse;
    rec = {61'b0, 1'b0, !input_pulse, input_pulse, counter};
    step(2);
    rd_en = 1'b1;
    step(1);
    rd_en = 1'b0;
    void'(q.pop_front());
    q.push_back(rec);
    check("t4_still_full", full, 1);
    check("t4_ovf", overflow_error, 0);
    drain("t4_drain");

    // level high across reset with an event in flight, then enable
    auto_start = 1'b0;
    input_pulse = 1'b0;
    step(4);
    input_pulse = 1'b1;
    step(1);
    s_axi_aresetn = 1'b0;
    step(2);
    check("t6_rst_empty", empty, 1);
    check("t6_rst_full", full, 0);
    check("t6_rst_dout", fifo_dout, 0);
    s_axi_aresetn = 1'b1;
    step(10);
    auto_start = 1'b1;
    step(10);
    check("t6_norec", empty, 1);
    auto_start = 1'b0;
    input_pulse = 1'b0;
    step(6);
    auto_start = 1'b1;
    step(4);
    check("t6_tracked", empty, 1);
    toggle(rec);
    check("t6_rise", fifo_dout, rec);
    pop();
    check("t6_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
